uart_tx_frame: RTL and testbench

UART transmitter, the TX-side counterpart of the UART_RX edge/bit counter and sampler path.
- Accepts a parallel byte with a valid strobe.
- Serializes it as start bit, data bits LSB first, optional parity, stop bit on TX_OUT.
- Holds each bit for `prescale` clk_TX cycles, matching the RX oversampling ratio.
- Sits between the system-side data source (FIFO/register file) and the serial line.

---
 rtl/uart_tx_frame.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: start / data (LSB first) / optional parity / stop serializer; start bit begins the cycle after acceptance.
// ready = !busy; with UART_TX_HOLD_BUF_EN a one-entry holding buffer makes ready = !buf_full for gapless frames.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_TX,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            prescale,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  ready
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [5:0]            edge_q, edge_d;
    logic [5:0]            p_q, p_d;
    logic [2:0]            bit_q, bit_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q, tx_d;
    logic                  accept, last_edge;
    logic [2:0]            nxt_bit;

    // Only 16 and 32 are honoured; everything else falls back to 8 clocks per bit.
    function automatic logic [5:0] decode_p(input logic [5:0] ps);
        case (ps)
            6'd16:   decode_p = 6'd16;
            6'd32:   decode_p = 6'd32;
            default: decode_p = 6'd8;
        endcase
    endfunction

`ifdef UART_TX_HOLD_BUF_EN
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                  buf_pe_q, buf_pe_d;
    logic                  buf_pt_q, buf_pt_d;
    logic [5:0]            buf_p_q, buf_p_d;
    logic                  buf_full_q, buf_full_d;

    assign ready = !buf_full_q;
`else
    assign ready = !busy;
`endif

    assign busy      = (state_q != IDLE);
    assign accept    = Data_Valid && ready;
    assign last_edge = (edge_q == p_q - 6'd1);
    assign nxt_bit   = bit_q + 3'd1;
    assign TX_OUT    = tx_q;

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        p_d       = p_q;
        tx_d      = tx_q;
`ifdef UART_TX_HOLD_BUF_EN
        buf_data_d = buf_data_q;
        buf_pe_d   = buf_pe_q;
        buf_pt_d   = buf_pt_q;
        buf_p_d    = buf_p_q;
        buf_full_d = buf_full_q;
        if (accept && busy) begin
            buf_data_d = P_DATA;
            buf_pe_d   = PAR_EN;
            buf_pt_d   = PAR_TYP;
            buf_p_d    = decode_p(prescale);
            buf_full_d = 1'b1;
        end
`endif
        if (state_q != IDLE)
            edge_d = last_edge ? 6'd0 : edge_q + 6'd1;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
`ifdef UART_TX_HOLD_BUF_EN
                // A frame buffered during the last stop cycle starts from here.
                if (buf_full_q) begin
                    data_d     = buf_data_q;
                    par_en_d   = buf_pe_q;
                    par_typ_d  = buf_pt_q;
                    p_d        = buf_p_q;
                    buf_full_d = 1'b0;
                    state_d    = START;
                    tx_d       = 1'b0;
                end else
`endif
                if (accept) begin
                    data_d    = P_DATA;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    p_d       = decode_p(prescale);
                    state_d   = START;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (last_edge) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (last_edge) begin
                    if (bit_q == 3'(DATA_WIDTH - 1)) begin
                        bit_d = 3'd0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = (^data_q) ^ par_typ_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = nxt_bit;
                        tx_d  = data_q[nxt_bit];
                    end
                end
            end
            PARITY: begin
                if (last_edge) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (last_edge) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
`ifdef UART_TX_HOLD_BUF_EN
                    if (buf_full_q) begin
                        data_d     = buf_data_q;
                        par_en_d   = buf_pe_q;
                        par_typ_d  = buf_pt_q;
                        p_d        = buf_p_q;
                        buf_full_d = 1'b0;
                        state_d    = START;
                        tx_d       = 1'b0;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_TX) begin
        if (rst) begin
            state_q   <= IDLE;
            edge_q    <= 6'd0;
            bit_q     <= 3'd0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            p_q       <= 6'd8;
            tx_q      <= 1'b1;
`ifdef UART_TX_HOLD_BUF_EN
            buf_data_q <= '0;
            buf_pe_q   <= 1'b0;
            buf_pt_q   <= 1'b0;
            buf_p_q    <= 6'd8;
            buf_full_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            p_q       <= p_d;
            tx_q      <= tx_d;
`ifdef UART_TX_HOLD_BUF_EN
            buf_data_q <= buf_data_d;
            buf_pe_q   <= buf_pe_d;
            buf_pt_q   <= buf_pt_d;
            buf_p_q    <= buf_p_d;
            buf_full_q <= buf_full_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: frames are given as hand-written bit strings in line order.
module tb_uart_tx_frame;

    logic       clk_TX = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       busy;
    logic       ready;

    int checks = 0;
    int errors = 0;

`ifdef UART_TX_HOLD_BUF_EN
    localparam logic BUSY_RDY = 1'b1;
`else
    localparam logic BUSY_RDY = 1'b0;
`endif

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk_TX     (clk_TX),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .ready      (ready)
    );

    always #5 clk_TX = ~clk_TX;

    task automatic tick();
        @(posedge clk_TX);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = ps;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
    endtask

    // bits[n-1] is the first bit on the line; cycles before 'skip' have already elapsed.
    task automatic check_frame(input string tag, input logic [15:0] bits, input int n, input int p,
                               input int skip, input logic exp_rdy);
        for (int idx = skip; idx < n * p; idx++) begin
            chk($sformatf("%s tx bit%0d cyc%0d", tag, idx / p, idx % p), 32'(TX_OUT), 32'(bits[n - 1 - idx / p]));
            chk($sformatf("%s busy cyc%0d", tag, idx), 32'(busy), 32'd1);
            chk($sformatf("%s ready cyc%0d", tag, idx), 32'(ready), 32'(exp_rdy));
            tick();
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " tx"}, 32'(TX_OUT), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 6'd8;
        repeat (3) tick();
        idle_chk("reset");
        rst = 1'b0;
        tick();
        idle_chk("post reset");

        // 0xA5, even parity, 8 clocks per bit
        send(8'hA5, 1'b1, 1'b0, 6'd8);
        check_frame("a5", 16'b0_10100101_0_1, 11, 8, 0, BUSY_RDY);
        idle_chk("a5 end");
        tick();

        // 0x01, odd parity, 16 clocks per bit; inputs changed right after acceptance
        send(8'h01, 1'b1, 1'b1, 6'd16);
        P_DATA   = 8'hFE;
        PAR_TYP  = 1'b0;
        PAR_EN   = 1'b0;
        prescale = 6'd8;
        check_frame("01", 16'b0_10000000_0_1, 11, 16, 0, BUSY_RDY);
        idle_chk("01 end");
        tick();

        // 0xFF no parity at 32, then a request on the first idle cycle
        send(8'hFF, 1'b0, 1'b0, 6'd32);
        check_frame("ff", 16'b0_11111111_1, 10, 32, 0, BUSY_RDY);
        idle_chk("ff gap");
        send(8'h00, 1'b0, 1'b0, 6'd8);
        check_frame("00", 16'b0_00000000_1, 10, 8, 0, BUSY_RDY);
        idle_chk("00 end");
        tick();

        // illegal prescale falls back to 8
        send(8'h3C, 1'b0, 1'b0, 6'd20);
        check_frame("3c", 16'b0_00111100_1, 10, 8, 0, BUSY_RDY);
        idle_chk("3c end");
        tick();

        // reset mid-frame, with a simultaneous request that must be dropped
        send(8'hA5, 1'b1, 1'b0, 6'd8);
        chk("abort tx start", 32'(TX_OUT), 32'd0);
        repeat (39) tick();
        rst        = 1'b1;
        Data_Valid = 1'b1;
        P_DATA     = 8'h00;
        tick();
        rst        = 1'b0;
        Data_Valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle_chk($sformatf("abort idle %0d", i));
            tick();
        end
        send(8'h5A, 1'b1, 1'b1, 6'd8);
        check_frame("5a", 16'b0_01011010_1_1, 11, 8, 0, BUSY_RDY);
        idle_chk("5a end");
        tick();

`ifdef UART_TX_HOLD_BUF_EN
        // buffered second frame, third request dropped while the buffer is full
        send(8'h55, 1'b0, 1'b0, 6'd8);
        chk("buf ready empty", 32'(ready), 32'd1);
        chk("buf busy", 32'(busy), 32'd1);
        send(8'hAA, 1'b0, 1'b0, 6'd8);
        chk("buf ready full", 32'(ready), 32'd0);
        send(8'h0F, 1'b1, 1'b1, 6'd16);
        check_frame("55", 16'b0_10101010_1, 10, 8, 2, 1'b0);
        check_frame("aa", 16'b0_01010101_1, 10, 8, 0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            idle_chk($sformatf("buf idle %0d", i));
            tick();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
